// File: rtl/id_ex_stage_if.sv
// Bundle of the decode stage's fetch, register-file, write-back, hazard and
// EX-register signals. The upstream driver uses the master view and the
// stage uses the slave view.
interface id_ex_stage_if;
  // fetch side
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;
  // register-file read port
  logic [4:0]  rs_num;
  logic [4:0]  rt_num;
  logic [31:0] rf_rs_data;
  logic [31:0] rf_rt_data;
  // write-back port (same signals the register file sees)
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  // hazard / control
  logic        ex_is_load;
  logic [4:0]  ex_load_dest;
  logic        flush;
  logic        stall;
  // EX pipeline register
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs_val;
  logic [31:0] ex_rt_val;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_rd;
  logic [4:0]  ex_shamt;
  logic [5:0]  ex_opcode;
  logic [5:0]  ex_funct;
  logic [15:0] stall_count;

  modport master (
    output if_instr, if_pc, if_valid,
    output rf_rs_data, rf_rt_data,
    output wb_we, wb_reg, wb_data,
    output ex_is_load, ex_load_dest, flush,
    input  rs_num, rt_num, stall,
    input  ex_valid, ex_pc, ex_rs_val, ex_rt_val, ex_imm,
    input  ex_rs, ex_rt, ex_rd, ex_shamt, ex_opcode, ex_funct,
    input  stall_count
  );

  modport slave (
    input  if_instr, if_pc, if_valid,
    input  rf_rs_data, rf_rt_data,
    input  wb_we, wb_reg, wb_data,
    input  ex_is_load, ex_load_dest, flush,
    output rs_num, rt_num, stall,
    output ex_valid, ex_pc, ex_rs_val, ex_rt_val, ex_imm,
    output ex_rs, ex_rt, ex_rd, ex_shamt, ex_opcode, ex_funct,
    output stall_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX stage: decodes the fetched instruction, forwards same-cycle
// write-back data past the register file, detects load-use hazards and
// holds the EX pipeline register. Flush beats stall; bubbles caused by
// load-use stalls are counted in a saturating counter.
module id_ex_stage #(
  // ceiling of the bubble counter
  parameter logic [15:0] STALL_SAT = 16'hFFFF
) (
  input logic         clk,
  input logic         rst_n,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  opcode;
    logic [5:0]  funct;
  } ex_reg_t;

  ex_reg_t     ex_q, ex_d;
  logic [15:0] cnt_q;

  logic [5:0]  opcode;
  logic [4:0]  rs, rt;
  logic        zext;
  logic        hazard;
  logic        stall;

  assign opcode = bus.if_instr[31:26];
  assign rs     = bus.if_instr[25:21];
  assign rt     = bus.if_instr[20:16];

  assign bus.rs_num = rs;
  assign bus.rt_num = rt;

  // logical immediates (andi/ori/xori) zero-extend, everything else sign-extends
  always_comb begin
    zext = 1'b0;
    case (opcode)
      6'h0C, 6'h0D, 6'h0E: zext = 1'b1;
      default:             zext = 1'b0;
    endcase
  end

  // load in EX whose destination feeds this instruction; $0 never hazards
  assign hazard = bus.if_valid && bus.ex_is_load && ex_q.valid &&
                  (bus.ex_load_dest != 5'd0) &&
                  ((bus.ex_load_dest == rs) || (bus.ex_load_dest == rt));
  assign stall  = hazard && !bus.flush;
  assign bus.stall = stall;

  // next EX contents: decoded fields plus write-back bypass of operands
  always_comb begin
    ex_d        = '0;
    ex_d.valid  = bus.if_valid;
    ex_d.pc     = bus.if_pc;
    ex_d.rs_val = (bus.wb_we && bus.wb_reg != 5'd0 && bus.wb_reg == rs) ?
                  bus.wb_data : bus.rf_rs_data;
    ex_d.rt_val = (bus.wb_we && bus.wb_reg != 5'd0 && bus.wb_reg == rt) ?
                  bus.wb_data : bus.rf_rt_data;
    ex_d.imm    = zext ? {16'h0000, bus.if_instr[15:0]} :
                         {{16{bus.if_instr[15]}}, bus.if_instr[15:0]};
    ex_d.rs     = rs;
    ex_d.rt     = rt;
    ex_d.rd     = bus.if_instr[15:11];
    ex_d.shamt  = bus.if_instr[10:6];
    ex_d.opcode = opcode;
    ex_d.funct  = bus.if_instr[5:0];
  end

  // EX register and bubble counter: flush > stall > capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else if (bus.flush) begin
      ex_q.valid <= 1'b0;
    end else if (stall) begin
      ex_q.valid <= 1'b0;
      if (cnt_q != STALL_SAT) cnt_q <= cnt_q + 16'd1;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_pc       = ex_q.pc;
  assign bus.ex_rs_val   = ex_q.rs_val;
  assign bus.ex_rt_val   = ex_q.rt_val;
  assign bus.ex_imm      = ex_q.imm;
  assign bus.ex_rs       = ex_q.rs;
  assign bus.ex_rt       = ex_q.rt;
  assign bus.ex_rd       = ex_q.rd;
  assign bus.ex_shamt    = ex_q.shamt;
  assign bus.ex_opcode   = ex_q.opcode;
  assign bus.ex_funct    = ex_q.funct;
  assign bus.stall_count = cnt_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: if_instr  in  32  fetched instruction; if_pc  in  32  its PC; if_valid  in  1  instruction present.
REQ-004 SHALL have ports: rs_num, rt_num  out  5  register-file read indices = if_instr[25:21], if_instr[20:16] (combinational).
REQ-005 SHALL have ports: rf_rs_data, rf_rt_data  in  32  register-file read data (index 0 reads 0).
REQ-006 SHALL have ports: wb_we  in  1, wb_reg  in  5, wb_data  in  32  write-back port, identical to the register-file write inputs.
REQ-007 SHALL have ports: ex_is_load  in  1, ex_load_dest  in  5  EX-stage load and its destination register.
REQ-008 SHALL have port: flush  in  1  taken branch/jump; discard the decoding instruction.
REQ-009 SHALL have port: stall  out  1  hold fetch PC and if_instr this cycle.
REQ-010 SHALL have registered outputs: ex_valid 1, ex_pc 32, ex_rs_val 32, ex_rt_val 32, ex_imm 32, ex_rs 5, ex_rt 5, ex_rd 5, ex_shamt 5, ex_opcode 6, ex_funct 6.
REQ-011 SHALL have output: stall_count  out  16  saturating count of load-use bubbles.

Function
REQ-012 SHALL bypass: rs value = wb_data when wb_we=1, wb_reg!=0, wb_reg==rs_num; else rf_rs_data. Same rule for rt.
REQ-013 SHALL assert stall combinationally when if_valid=1, ex_is_load=1, ex_load_dest!=0, ex_valid=1, and ex_load_dest equals rs_num or rt_num; and flush=0.
REQ-014 SHALL, on each rising edge with flush=1, load ex_valid=0 (bubble); other ex_* fields don't-care; stall forced 0.
REQ-015 SHALL, on each rising edge with stall=1, load ex_valid=0 and increment stall_count, saturating at 16'hFFFF.
REQ-016 SHALL otherwise load ex_valid=if_valid and capture all fields from if_instr/if_pc and bypassed values.
REQ-017 SHALL decode fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6], funct [5:0].
REQ-018 SHALL zero-extend instr[15:0] into ex_imm for opcodes 6'h0C, 6'h0D, 6'h0E; sign-extend for all others.
REQ-019 SHALL give flush priority over stall when both conditions hold in the same cycle.
REQ-020 SHALL NOT compare against register 0 for stall or bypass; index 0 always yields 0 from the register file.
REQ-021 SHALL have latency of one cycle from if_* to ex_*; no internal queueing beyond one instruction.

Reset
REQ-022 SHALL, while rst_n=0, asynchronously clear ex_valid, all ex_* fields, and stall_count to 0.
REQ-023 SHALL resume normal capture on the first rising edge after rst_n deasserts; reset mid-stall discards the bubble count increment for that edge.

Verification
REQ-024 Bypass: rf_rs_data=0x11, wb_we=1, wb_reg=rs_num=5, wb_data=0xDEADBEEF -> next edge ex_rs_val=0xDEADBEEF, ex_valid=1.
REQ-025 Load-use: ex_valid=1, ex_is_load=1, ex_load_dest=8, if_instr rt=8 -> stall=1, next edge ex_valid=0, stall_count=1; load then leaves EX -> instruction captured with ex_valid=1.
REQ-026 Reg-0: ex_is_load=1, ex_load_dest=0, rs_num=0 -> stall=0; wb_reg=0, wb_we=1, wb_data=0xFFFF_FFFF -> ex_rs_val=0.
REQ-027 Flush+stall: both conditions true -> stall=0, ex_valid=0, stall_count unchanged.
REQ-028 Immediates: if_instr=0x3402FFFF (ori) -> ex_imm=0x0000FFFF; if_instr=0x2002FFFF (addi) -> ex_imm=0xFFFFFFFF.
REQ-029 Reset/saturation: preload stall_count=0xFFFF via 65535 stalls, one more stall -> stays 0xFFFF; drop rst_n mid-cycle -> outputs 0 before next edge.
